mul_bist_ctrl: RTL and testbench
================================

MUL_BIST_CTRL -- requirements
Module: mul_bist_ctrl

Interface
REQ-001 The module SHALL have parameter MUL_LATENCY, default 1, giving the multiplier's operand-to-output latency in cycles (1..4).
REQ-002 The module SHALL have parameter SEED_A, default 32'hACE1_2468, as the non-zero LFSR seed for operand A.
REQ-003 The module SHALL have parameter SEED_B, default 32'h1357_BDF1, as the non-zero LFSR seed for operand B.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port start, input, 1 bit: begins a test run when sampled high in IDLE.
REQ-007 The module SHALL have port num_vectors, input, 16 bits: number of vectors per precision, sampled on start.
REQ-008 The module SHALL have port operand_a_32bit, output, 32 bits: operand A driven to the multiplier.
REQ-009 The module SHALL have port operand_b_32bit, output, 32 bits: operand B driven to the multiplier.
REQ-010 The module SHALL have port precision, output, 2 bits: multiplier precision (00 = 8-bit lanes, 01 = 16-bit lanes, 10 = 32-bit).
REQ-011 The module SHALL have port output_32bit_mul, input, 64 bits: the multiplier result.
REQ-012 The module SHALL have ports busy and done, outputs, 1 bit each: run in progress, and run complete (held until the next start).
REQ-013 The module SHALL have ports pass_count and fail_count, outputs, 32 bits each: per-lane check counters.
REQ-014 The module SHALL have ports first_fail_a, first_fail_b (32 bits each) and first_fail_prec (2 bits), outputs: operands and precision of the first mismatch.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN and DONE, plus a 2-bit precision index stepping 10 -> 01 -> 00.
REQ-016 On start in IDLE or DONE, the block SHALL clear counters, first_fail_* and done, latch num_vectors, load both LFSRs with their seeds, set precision=10 and enter RUN; start SHALL be ignored while busy.
REQ-017 In RUN the block SHALL issue one new A/B pair per cycle from two 32-bit Galois LFSRs (polynomial x^32+x^22+x^2+x+1) for exactly N cycles, then enter DRAIN.
REQ-018 DRAIN SHALL last MUL_LATENCY cycles, holding operands and precision; then go to RUN with the next precision, or go to DONE after precision 00.
REQ-019 If N=0, the block SHALL go from the start edge directly to DONE with zero counts.
REQ-020 The expected result SHALL be computed with unsigned products at issue: 32x32->64 for precision 10; two 16x16->32 lanes for 01 (lane i in bits [32i+31:32i]); four 8x8->16 lanes for 00 (lane i in bits [16i+15:16i]).
REQ-021 The expected value, precision tag, operands and valid bit SHALL be delayed MUL_LATENCY cycles and compared with output_32bit_mul.
REQ-022 The compare SHALL be per lane: each matching lane increments pass_count, and each mismatching lane increments fail_count.
REQ-023 pass_count and fail_count SHALL saturate at 32'hFFFF_FFFF.
REQ-024 first_fail_* SHALL capture only the first mismatching vector of a run.
REQ-025 Precision SHALL change only on the RUN entry edge, so no in-flight check uses a stale tag.
REQ-026 busy SHALL be 1 in RUN and DRAIN; done SHALL be 1 only in DONE.
REQ-027 Total time from the start edge to done=1 SHALL be 3*(N+MUL_LATENCY) cycles.

Reset
REQ-028 rst low SHALL immediately force IDLE with busy=0, done=0, counters=0, first_fail_*=0, operands=0, precision=10 and pipeline valids=0.
REQ-029 Reset mid-run SHALL abort the run, and no check SHALL be counted from vectors issued before the reset.

Structure
REQ-030 A shared package mul_bist_pkg SHALL hold the state enum, precision encodings (PREC_8/16/32), LFSR polynomial and default seeds.
REQ-031 One sub-module, mul_bist_lfsr32 (seedable Galois LFSR with load/enable), SHALL be instantiated twice; the compare pipeline stays in the top module.

Verification
REQ-032 Correct multiplier (latency 1), N=1000 -> done at cycle 3003, pass_count=7000, fail_count=0.
REQ-033 Multiplier result bit 0 stuck at 0, N=100 -> fail_count>0, pass_count+fail_count=700, and first_fail_prec=10.
REQ-034 N=0 -> done=1 on the cycle after start, and counts are 0.
REQ-035 start pulsed again mid-run -> ignored, and final counts are identical to an undisturbed run.
REQ-036 rst asserted during the 01 sweep, then start with N=10 -> pass_count=70 and fail_count=0.
REQ-037 MUL_LATENCY=3 with a 3-stage multiplier, N=50 -> done at cycle 159, pass_count=350.

Source files
------------

// File: rtl/mul_bist_ctrl_pkg.sv
// mul_bist_pkg: shared definitions for the multiplier BIST controller.
//   - FSM state encodings (legacy localparams) and the state enum built on them
//   - precision encodings PREC_8 / PREC_16 / PREC_32
//   - LFSR feedback mask and default seeds
//   - check-pipeline entry type and the reference product helper
package mul_bist_pkg;

   typedef logic [1:0] prec_t;

   localparam prec_t PREC_8  = 2'b00;
   localparam prec_t PREC_16 = 2'b01;
   localparam prec_t PREC_32 = 2'b10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_RUN   = ST_RUN,
      S_DRAIN = ST_DRAIN,
      S_DONE  = ST_DONE
   } state_e;

   // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
   localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;
   localparam logic [31:0] SEED_A_DEFAULT = 32'hACE1_2468;
   localparam logic [31:0] SEED_B_DEFAULT = 32'h1357_BDF1;

   typedef struct packed {
      logic        vld;
      prec_t       prec;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } chk_t;

   // Unsigned lane-wise product laid out the way the multiplier returns it.
   function automatic logic [63:0] expected_product(input logic [31:0] a,
                                                    input logic [31:0] b,
                                                    input prec_t       prec);
      logic [63:0] r;
      r = '0;
      case (prec)
         PREC_32: r = 64'(a) * 64'(b);
         PREC_16: begin
            r[31:0]  = 32'(a[15:0])  * 32'(b[15:0]);
            r[63:32] = 32'(a[31:16]) * 32'(b[31:16]);
         end
         PREC_8: begin
            r[15:0]  = 16'(a[7:0])   * 16'(b[7:0]);
            r[31:16] = 16'(a[15:8])  * 16'(b[15:8]);
            r[47:32] = 16'(a[23:16]) * 16'(b[23:16]);
            r[63:48] = 16'(a[31:24]) * 16'(b[31:24]);
         end
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mul_bist_ctrl_if.sv
// mul_bist_ctrl_if: operand/result bus between the BIST controller and the
// multiplier under test.
//   operand_a_32bit, operand_b_32bit : operands (controller -> multiplier)
//   precision                        : lane mode  (controller -> multiplier)
//   output_32bit_mul                 : result     (multiplier -> controller)
interface mul_bist_ctrl_if
   import mul_bist_pkg::*;
   ;
   logic [31:0] operand_a_32bit;
   logic [31:0] operand_b_32bit;
   prec_t       precision;
   logic [63:0] output_32bit_mul;

   modport master (
      output operand_a_32bit,
      output operand_b_32bit,
      output precision,
      input  output_32bit_mul
   );

   modport slave (
      input  operand_a_32bit,
      input  operand_b_32bit,
      input  precision,
      output output_32bit_mul
   );
endinterface

// File: rtl/mul_bist_lfsr32.sv
// mul_bist_lfsr32: 32-bit Galois LFSR with synchronous seed load and enable.
//   clk, rst_n : clock, asynchronous active-low reset (state clears to 0)
//   load, seed : load seed on the next edge (has priority over en)
//   en         : advance one step on the next edge
//   state      : current register value
module mul_bist_lfsr32
   import mul_bist_pkg::*;
#(
   parameter logic [31:0] POLY = LFSR_POLY
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        en,
   input  logic [31:0] seed,
   output logic [31:0] state
);

   logic [31:0] state_q;
   logic [31:0] state_d;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = seed;
      end else if (en) begin
         state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? POLY : '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/mul_bist_ctrl.sv
// mul_bist_ctrl: built-in self test controller for a lane-configurable
// multiplier. Sweeps precision 32 -> 16 -> 8, issuing LFSR operand pairs and
// checking every lane of the delayed result against a locally computed product.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : begin a run (IDLE/DONE only)
//   num_vectors     : vectors per precision, latched on start
//   mul             : operand/precision out, result in (master modport)
//   busy, done      : run in progress / run complete
//   pass_count      : saturating count of matching lanes
//   fail_count      : saturating count of mismatching lanes
//   first_fail_*    : operands and precision of the first failing vector
module mul_bist_ctrl
   import mul_bist_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 1,
   parameter logic [31:0] SEED_A      = SEED_A_DEFAULT,
   parameter logic [31:0] SEED_B      = SEED_B_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [15:0]           num_vectors,
   mul_bist_ctrl_if.master       mul,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           pass_count,
   output logic [31:0]           fail_count,
   output logic [31:0]           first_fail_a,
   output logic [31:0]           first_fail_b,
   output logic [1:0]            first_fail_prec
);

   state_e      state_q, state_d;
   prec_t       prec_q, prec_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] n_q, n_d;
   logic [31:0] pass_q, pass_d;
   logic [31:0] fail_q, fail_d;
   logic [31:0] ffa_q, ffa_d;
   logic [31:0] ffb_q, ffb_d;
   prec_t       ffp_q, ffp_d;
   logic        ff_seen_q, ff_seen_d;
   chk_t        pipe_q [MUL_LATENCY];
   chk_t        pipe_d [MUL_LATENCY];

   logic        start_accept;
   logic [31:0] lfsr_a, lfsr_b;
   chk_t        issue;
   chk_t        chk_out;
   logic [2:0]  pass_inc, fail_inc;

   function automatic logic [31:0] sat_add(input logic [31:0] c,
                                           input logic [2:0]  inc);
      logic [32:0] s;
      s = {1'b0, c} + 33'(inc);
      return s[32] ? '1 : s[31:0];
   endfunction

   mul_bist_lfsr32 #(.POLY(LFSR_POLY)) u_lfsr_a (
      .clk   (clk),
      .rst_n (rst),
      .load  (start_accept),
      .en    (state_q == S_RUN),
      .seed  (SEED_A),
      .state (lfsr_a)
   );

   mul_bist_lfsr32 #(.POLY(LFSR_POLY)) u_lfsr_b (
      .clk   (clk),
      .rst_n (rst),
      .load  (start_accept),
      .en    (state_q == S_RUN),
      .seed  (SEED_B),
      .state (lfsr_b)
   );

   // The LFSR advances on every RUN edge, so the value held through DRAIN is
   // the first operand pair of the next precision sweep.
   always_comb begin
      issue.vld  = (state_q == S_RUN);
      issue.prec = prec_q;
      issue.a    = lfsr_a;
      issue.b    = lfsr_b;
      issue.exp  = expected_product(lfsr_a, lfsr_b, prec_q);
   end

   assign chk_out = pipe_q[MUL_LATENCY-1];

   // Per-lane compare of the pipeline tail against the multiplier output.
   always_comb begin
      pass_inc = '0;
      fail_inc = '0;
      if (chk_out.vld) begin
         case (chk_out.prec)
            PREC_32: begin
               if (mul.output_32bit_mul == chk_out.exp) pass_inc = 3'd1;
               else                                     fail_inc = 3'd1;
            end
            PREC_16: begin
               for (int unsigned i = 0; i < 2; i++) begin
                  if (mul.output_32bit_mul[i*32 +: 32] == chk_out.exp[i*32 +: 32])
                     pass_inc = pass_inc + 3'd1;
                  else
                     fail_inc = fail_inc + 3'd1;
               end
            end
            PREC_8: begin
               for (int unsigned i = 0; i < 4; i++) begin
                  if (mul.output_32bit_mul[i*16 +: 16] == chk_out.exp[i*16 +: 16])
                     pass_inc = pass_inc + 3'd1;
                  else
                     fail_inc = fail_inc + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      prec_d       = prec_q;
      cnt_d        = cnt_q;
      n_d          = n_q;
      start_accept = 1'b0;

      pipe_d[0] = issue;
      for (int unsigned i = 1; i < MUL_LATENCY; i++) pipe_d[i] = pipe_q[i-1];

      pass_d    = sat_add(pass_q, pass_inc);
      fail_d    = sat_add(fail_q, fail_inc);
      ffa_d     = ffa_q;
      ffb_d     = ffb_q;
      ffp_d     = ffp_q;
      ff_seen_d = ff_seen_q;
      if ((fail_inc != 3'd0) && !ff_seen_q) begin
         ff_seen_d = 1'b1;
         ffa_d     = chk_out.a;
         ffb_d     = chk_out.b;
         ffp_d     = chk_out.prec;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               start_accept = 1'b1;
               pass_d       = '0;
               fail_d       = '0;
               ffa_d        = '0;
               ffb_d        = '0;
               ffp_d        = '0;
               ff_seen_d    = 1'b0;
               n_d          = num_vectors;
               prec_d       = PREC_32;
               cnt_d        = num_vectors - 16'd1;
               state_d      = (num_vectors == 16'd0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q == 16'd0) begin
               state_d = S_DRAIN;
               cnt_d   = 16'(MUL_LATENCY - 1);
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_DRAIN: begin
            // Draining exactly MUL_LATENCY cycles means the last check of a
            // sweep lands on the same edge that retags precision.
            if (cnt_q == 16'd0) begin
               if (prec_q == PREC_8) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
                  prec_d  = prec_q - 2'd1;
                  cnt_d   = n_q - 16'd1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         prec_q    <= PREC_32;
         cnt_q     <= '0;
         n_q       <= '0;
         pass_q    <= '0;
         fail_q    <= '0;
         ffa_q     <= '0;
         ffb_q     <= '0;
         ffp_q     <= '0;
         ff_seen_q <= 1'b0;
         for (int unsigned i = 0; i < MUL_LATENCY; i++) pipe_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         prec_q    <= prec_d;
         cnt_q     <= cnt_d;
         n_q       <= n_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         ffa_q     <= ffa_d;
         ffb_q     <= ffb_d;
         ffp_q     <= ffp_d;
         ff_seen_q <= ff_seen_d;
         pipe_q    <= pipe_d;
      end
   end

   assign mul.operand_a_32bit = lfsr_a;
   assign mul.operand_b_32bit = lfsr_b;
   assign mul.precision       = prec_q;
   assign busy                = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done                = (state_q == S_DONE);
   assign pass_count          = pass_q;
   assign fail_count          = fail_q;
   assign first_fail_a        = ffa_q;
   assign first_fail_b        = ffb_q;
   assign first_fail_prec     = ffp_q;

endmodule

// File: tb/tb_mul_bist_ctrl.sv
// Bench for mul_bist_ctrl: two instances (latency 1 and latency 3) driven by
// behavioural multipliers with an optional result-bit-0 stuck-at-0 fault.
module tb_mul_bist_ctrl;

   localparam logic [31:0] SEED_A = 32'hACE1_2468;
   localparam logic [31:0] SEED_B = 32'h1357_BDF1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] nv;
   int          sel;
   bit          fault_en;
   int          n_total = 0;
   int          n_pass  = 0;

   always #5 clk = ~clk;

   logic start1, start3;
   assign start1 = start && (sel == 0);
   assign start3 = start && (sel == 1);

   mul_bist_ctrl_if mif1 ();
   mul_bist_ctrl_if mif3 ();

   logic        busy1, done1, busy3, done3;
   logic [31:0] pass1, fail1, ffa1, ffb1, pass3, fail3, ffa3, ffb3;
   logic [1:0]  ffp1, ffp3;

   mul_bist_ctrl #(.MUL_LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst_n), .start(start1), .num_vectors(nv), .mul(mif1),
      .busy(busy1), .done(done1), .pass_count(pass1), .fail_count(fail1),
      .first_fail_a(ffa1), .first_fail_b(ffb1), .first_fail_prec(ffp1)
   );

   mul_bist_ctrl #(.MUL_LATENCY(3)) u_dut3 (
      .clk(clk), .rst(rst_n), .start(start3), .num_vectors(nv), .mul(mif3),
      .busy(busy3), .done(done3), .pass_count(pass3), .fail_count(fail3),
      .first_fail_a(ffa3), .first_fail_b(ffb3), .first_fail_prec(ffp3)
   );

   function automatic int lanes_of(input logic [1:0] p);
      return (p == 2'b10) ? 1 : (p == 2'b01) ? 2 : 4;
   endfunction

   // Multiply each operand lane as an unsigned number and place the
   // double-width product in the matching result lane.
   function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [1:0]  p);
      int          lanes, w;
      logic [63:0] r, aa, bb, mask, x, y;
      lanes = lanes_of(p);
      w     = 32 / lanes;
      r     = 64'd0;
      aa    = {32'd0, a};
      bb    = {32'd0, b};
      mask  = (64'd1 << w) - 64'd1;
      for (int i = 0; i < lanes; i++) begin
         x = (aa >> (i * w)) & mask;
         y = (bb >> (i * w)) & mask;
         r = r | ((x * y) << (i * 2 * w));
      end
      return r;
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      logic [31:0] taps;
      taps = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
      return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
   endfunction

   // Behavioural multipliers
   logic [63:0] m1_q;
   logic [63:0] m3_q [3];
   always @(posedge clk) begin
      m1_q    <= ref_mul(mif1.operand_a_32bit, mif1.operand_b_32bit, mif1.precision);
      m3_q[0] <= ref_mul(mif3.operand_a_32bit, mif3.operand_b_32bit, mif3.precision);
      m3_q[1] <= m3_q[0];
      m3_q[2] <= m3_q[1];
   end
   assign mif1.output_32bit_mul = fault_en ? (m1_q & ~64'd1) : m1_q;
   assign mif3.output_32bit_mul = fault_en ? (m3_q[2] & ~64'd1) : m3_q[2];

   // View of the currently selected instance
   logic        busy_s, done_s;
   logic [31:0] pass_s, fail_s, ffa_s, ffb_s, opa_s, opb_s;
   logic [1:0]  ffp_s, prec_s;
   always_comb begin
      if (sel == 0) begin
         busy_s = busy1; done_s = done1; pass_s = pass1; fail_s = fail1;
         ffa_s = ffa1; ffb_s = ffb1; ffp_s = ffp1;
         opa_s = mif1.operand_a_32bit; opb_s = mif1.operand_b_32bit;
         prec_s = mif1.precision;
      end else begin
         busy_s = busy3; done_s = done3; pass_s = pass3; fail_s = fail3;
         ffa_s = ffa3; ffb_s = ffb3; ffp_s = ffp3;
         opa_s = mif3.operand_a_32bit; opb_s = mif3.operand_b_32bit;
         prec_s = mif3.precision;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Whole-run prediction: three sweeps of n vectors, one LFSR pair per vector,
   // lane-by-lane comparison against the (possibly faulty) multiplier.
   task automatic model_run(input int n, input bit fault,
                            output longint p, output longint f,
                            output logic [31:0] fa, output logic [31:0] fb,
                            output logic [1:0] fp);
      logic [31:0] la, lb;
      logic [63:0] good, bad, diff;
      logic [1:0]  pr;
      int          lanes, rw;
      bit          seen, miss;
      la = SEED_A; lb = SEED_B; seen = 0;
      p = 0; f = 0; fa = '0; fb = '0; fp = '0;
      for (int s = 0; s < 3; s++) begin
         pr = 2'(2 - s);
         for (int k = 0; k < n; k++) begin
            good  = ref_mul(la, lb, pr);
            bad   = fault ? (good & ~64'd1) : good;
            diff  = good ^ bad;
            lanes = lanes_of(pr);
            rw    = 64 / lanes;
            miss  = 0;
            for (int i = 0; i < lanes; i++) begin
               if (((diff >> (i * rw)) << (64 - rw)) == 64'd0) p++;
               else begin f++; miss = 1; end
            end
            if (miss && !seen) begin
               seen = 1; fa = la; fb = lb; fp = pr;
            end
            la = lfsr_next(la);
            lb = lfsr_next(lb);
         end
      end
   endtask

   task automatic do_run(input int d, input int n, input bit fault, input int restart_at);
      int          lat, cycles, limit, exp_cycles;
      longint      ep, ef;
      logic [31:0] ea, eb;
      logic [1:0]  epr;
      string       tg;
      lat        = (d == 0) ? 1 : 3;
      cycles     = 0;
      limit      = 3 * (n + lat) + 20;
      exp_cycles = (n == 0) ? 0 : 3 * (n + lat);
      tg         = $sformatf("L%0d_n%0d_f%0d", lat, n, fault);
      model_run(n, fault, ep, ef, ea, eb, epr);
      @(negedge clk);
      sel = d; fault_en = fault; nv = 16'(n); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      nv    = 16'($urandom);
      if (n > 0) begin
         check({tg, "_first_a"}, opa_s, SEED_A);
         check({tg, "_first_b"}, opb_s, SEED_B);
         check({tg, "_busy"}, busy_s, 1'b1);
      end
      while (done_s !== 1'b1 && cycles < limit) begin
         @(posedge clk); #1;
         cycles++;
         if (cycles == restart_at) begin
            start = 1'b1; nv = 16'(n + 5);
         end else if (cycles == restart_at + 1) begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check({tg, "_cycles"}, 64'(cycles), 64'(exp_cycles));
      check({tg, "_done"}, done_s, 1'b1);
      check({tg, "_idle"}, busy_s, 1'b0);
      check({tg, "_pass"}, pass_s, ep);
      check({tg, "_fail"}, fail_s, ef);
      check({tg, "_ff_a"}, ffa_s, ea);
      check({tg, "_ff_b"}, ffb_s, eb);
      check({tg, "_ff_prec"}, ffp_s, epr);
   endtask

   initial begin
      int n, w;
      rst_n = 1'b0; start = 1'b0; nv = '0; sel = 0; fault_en = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         sel = d;
         #1;
         check("rst_busy", busy_s, 1'b0);
         check("rst_done", done_s, 1'b0);
         check("rst_pass", pass_s, 32'd0);
         check("rst_fail", fail_s, 32'd0);
         check("rst_op_a", opa_s, 32'd0);
         check("rst_op_b", opb_s, 32'd0);
         check("rst_prec", prec_s, 2'b10);
         check("rst_ff_a", ffa_s, 32'd0);
         check("rst_ff_prec", ffp_s, 2'b00);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Golden multiplier, N=1000: 3003 cycles, 7000 passes
      do_run(0, 1000, 0, -1);
      check("n1000_pass_total", pass_s, 32'd7000);

      // Stuck-at-0 on result bit 0
      do_run(0, 100, 1, -1);
      check("fault_sum", 64'(pass_s) + 64'(fail_s), 64'd700);
      check("fault_prec32", ffp_s, 2'b10);

      // Zero vectors on both instances
      do_run(0, 0, 0, -1);
      do_run(1, 0, 0, -1);

      // Random lengths, instances and fault injection
      repeat (4) begin
         do_run($urandom_range(0, 1), $urandom_range(1, 40), bit'($urandom_range(0, 1)), -1);
      end

      // Start pulsed mid-run must be ignored
      n = $urandom_range(5, 30);
      do_run(0, n, 0, $urandom_range(1, 3 * (n + 1) - 2));
      n = $urandom_range(5, 30);
      do_run(1, n, 1, $urandom_range(1, 3 * (n + 3) - 2));

      // Reset during the 16-bit sweep of a latency-3 run
      @(negedge clk);
      sel = 1; fault_en = 0; nv = 16'd20; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      w = 0;
      while (prec_s !== 2'b01 && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      check("reach_prec16", prec_s, 2'b01);
      repeat ($urandom_range(0, 10)) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy_s, 1'b0);
      check("midrst_done", done_s, 1'b0);
      check("midrst_prec", prec_s, 2'b10);
      check("midrst_op_a", opa_s, 32'd0);
      check("midrst_pass", pass_s, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_run(1, 10, 0, -1);
      check("after_rst_pass70", pass_s, 32'd70);

      // Latency 3, N=50: 159 cycles, 350 passes
      do_run(1, 50, 0, -1);
      check("lat3_pass350", pass_s, 32'd350);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
